sfifo_burst_drain: RTL and testbench
====================================

// Module: sfifo_burst_drain
// PURPOSE
//  Downstream consumer of sfifo (RD_MUX=0 flavour). Pops the FIFO head and streams it out on a valid/ready
//  interface. Output is framed into bursts of up to MAX_BURST beats with sop/eop markers.
//  A burst starts when FIFO occupancy passes the FIFO's ETHRESH (fifo_tempty low), or when data has waited
//  TIMEOUT cycles. Output is registered through a 2-entry skid buffer, so out_rdy never reaches fifo_rd combinationally.
// PARAMETERS
//  WIDTH     4      data width; must match the sfifo WIDTH
//  DEPTH     4      depth of the feeding sfifo; sets NV_WIDTH
//  MAX_BURST 4      maximum beats per burst, >=1
//  TIMEOUT   16     cycles of partial occupancy before a forced burst, >=1
//  NV_WIDTH  derived, do not override: (DEPTH==1 ? 1 : $clog2(DEPTH))+1, same as sfifo num_vld
// PORTS
//  clk           in   1         clock
//  rst_n         in   1         asynchronous active-low reset
//  flush         in   1         sync clear of state, counters and skid; tie to the same strobe as sfifo.flush
//  fifo_rd       out  1         pop strobe to sfifo.rd
//  fifo_rd_data  in   WIDTH     sfifo.rd_data (head; valid while !fifo_empty)
//  fifo_empty    in   1         sfifo.empty
//  fifo_tempty   in   1         sfifo.tempty
//  fifo_num_vld  in   NV_WIDTH  sfifo.num_vld
//  out_vld       out  1         output beat valid
//  out_rdy       in   1         output beat accepted when out_vld&out_rdy
//  out_data      out  WIDTH     beat data
//  out_sop       out  1         first beat of burst
//  out_eop       out  1         last beat of burst
//  timeout_evt   out  1         1-cycle pulse: burst started by timeout
//  busy          out  1         state!=IDLE or skid not empty
// BEHAVIOUR
//  Reset: state=IDLE, timers/counters 0, skid empty; out_vld/out_sop/out_eop/timeout_evt/busy=0, out_data=0.
//  FSM (registered state):
//   IDLE : !fifo_empty -> WAIT, timer=0.
//   WAIT : !fifo_tempty -> BURST. Else if timer==TIMEOUT-1 -> BURST and pulse timeout_evt next cycle.
//          Else timer++ (saturates). Width $clog2(TIMEOUT+1).
//   BURST: fifo_rd = !fifo_empty & (skid_cnt<2); beat_cnt counts pops, width $clog2(MAX_BURST+1).
//          Each popped beat captures {fifo_rd_data, sop=(beat_cnt==0), eop} into the skid in the same cycle.
//          eop = (beat_cnt==MAX_BURST-1) | (fifo_num_vld==1). A write in the same cycle does not extend the burst.
//          A pop with eop -> IDLE, beat_cnt=0. If fifo_empty while in BURST, stay and pop nothing.
//  fifo_rd is 0 outside BURST. Never pop when fifo_empty, so the sfifo udf flag must never set.
//  Latency: beat popped in cycle N is presented on out_* in N+1 at the earliest.
//  Skid (2 entries, FIFO order): out_* driven from entry 0 flops. Push and drain in the same cycle is allowed.
//   skid_cnt<2 gate plus same-cycle drain sustains 1 beat/cycle when out_rdy=1.
//  Stream rules: once out_vld=1, out_data/sop/eop hold until accepted. Flush is the sole exception.
//  Flush: highest priority. Next cycle state=IDLE, counters 0, skid empty, out_vld=0, fifo_rd=0 in the flush cycle.
//   A burst in progress is truncated with no eop; the consumer treats flush as a frame abort.
//  MAX_BURST==1: every beat is both sop and eop. TIMEOUT==1: WAIT forces BURST after 1 cycle.
//  rst_n assertion mid-burst: immediate async return to reset values.
// STRUCTURE
//  sfifo_drain_pkg: state enum {IDLE,WAIT,BURST} (2-bit), beat struct {data,sop,eop} via parameterized typedef
//   or macro, DRAIN_IDLE encoding constant.
//  Sub-module sfifo_skid2: generic 2-entry valid/ready skid buffer, parameter W.
//   Ports: push, push_data, full/cnt, pop_rdy, out_vld, out_data.
//  Top holds the FSM, the timer, beat_cnt, eop logic and the fifo_rd gate.
// TESTING (bench instantiates sfifo DEPTH=4, ETHRESH=2, RD_MUX=0 feeding this block, MAX_BURST=4, TIMEOUT=16)
//  1 Write 4 beats 0x1..0x4 back-to-back, out_rdy=1 -> WAIT 1 cycle after tempty drops, then 4 beats 1,2,3,4;
//    sop on 0x1, eop on 0x4, no timeout_evt.
//  2 Write 1 beat 0xA, no more -> timeout_evt exactly 16 cycles after WAIT entry; single beat with sop=eop=1.
//  3 Write 4 beats, hold out_rdy=0 -> exactly 2 pops (skid full), out_vld/data stable.
//    Release out_rdy -> remaining beats in order, no loss or duplication.
//  4 Continuous writes with MAX_BURST=4 -> eop every 4th beat, next sop only after a return through IDLE/WAIT.
//  5 Flush mid-burst after 2 beats accepted -> next cycle out_vld=0, busy=0, sfifo empty.
//    New writes restart with sop=1.
//  6 Random wr/out_rdy for 10k cycles vs scoreboard -> sfifo udf/ovf never set, data order preserved,
//    sop/eop well-formed (excepting flush).

Source files
------------

// File: rtl/sfifo_drain_pkg.sv
// Shared types for the sfifo burst drain: FSM state encoding and the
// occupancy-count width helper that mirrors the feeding sfifo.
package sfifo_drain_pkg;

  localparam logic [1:0] DRAIN_IDLE = 2'd0;

  typedef enum logic [1:0] {
    IDLE  = DRAIN_IDLE,
    WAIT  = 2'd1,
    BURST = 2'd2
  } drain_state_e;

  // Width of sfifo.num_vld for a given FIFO depth.
  function automatic int nv_width(input int depth);
    return ((depth == 1) ? 1 : $clog2(depth)) + 1;
  endfunction

endpackage

// File: rtl/sfifo_burst_drain_if.sv
// Framed valid/ready output stream of the burst drain.
interface sfifo_burst_drain_if #(
  parameter int WIDTH = 4
);
  logic             out_vld;
  logic             out_rdy;
  logic [WIDTH-1:0] out_data;
  logic             out_sop;
  logic             out_eop;

  modport master (output out_vld, out_data, out_sop, out_eop, input out_rdy);
  modport slave  (input out_vld, out_data, out_sop, out_eop, output out_rdy);
endinterface

// File: rtl/sfifo_skid2.sv
// Generic 2-entry valid/ready skid buffer in FIFO order; the output always
// comes from entry 0, so out_vld/out_data are straight from flops.
module sfifo_skid2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         full,
  output logic [1:0]   cnt,
  input  logic         pop_rdy,
  output logic         out_vld,
  output logic [W-1:0] out_data
);

  logic [W-1:0] ent0;
  logic [W-1:0] ent1;
  logic         pop;
  logic         put;

  assign out_vld  = (cnt != 2'd0);
  assign full     = (cnt == 2'd2);
  assign pop      = out_vld && pop_rdy;
  assign put      = push && (!full || pop);
  assign out_data = ent0;

  // NOTE: the two entries are reset as well as the count, because the
  // output data is taken straight from entry 0 and must read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= 2'd0;
      ent0 <= '0;
      ent1 <= '0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments let ent0 take the old ent1 while ent1
      // is overwritten in the same edge, without ordering hazards.
      unique case ({put, pop})
        2'b10: begin
          if (cnt == 2'd0) ent0 <= push_data;
          else             ent1 <= push_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            ent0 <= push_data;
          end else begin
            ent0 <= ent1;
            ent1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sfifo_burst_drain.sv
// Drains an sfifo (RD_MUX=0) into sop/eop-framed bursts of up to MAX_BURST
// beats, started by the FIFO threshold or by a wait timeout.
module sfifo_burst_drain
  import sfifo_drain_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 4,
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 16,
  parameter int NV_WIDTH  = nv_width(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  output logic                fifo_rd,
  input  logic [WIDTH-1:0]    fifo_rd_data,
  input  logic                fifo_empty,
  input  logic                fifo_tempty,
  input  logic [NV_WIDTH-1:0] fifo_num_vld,
  sfifo_burst_drain_if.master st,
  output logic                timeout_evt,
  output logic                busy
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [TW-1:0] TMR_LAST  = TW'(TIMEOUT - 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BURST - 1);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             sop;
    logic             eop;
  } beat_t;

  drain_state_e  state;
  logic [TW-1:0] timer;
  logic [BW-1:0] beat_cnt;
  logic          beat_eop;
  logic          skid_full;
  logic          skid_vld;
  logic [1:0]    skid_cnt;
  beat_t         push_beat;
  beat_t         head;

  // A beat closes the burst at the size limit or when it is the last word in
  // the FIFO; a write landing in the same cycle does not extend the burst.
  assign beat_eop = (beat_cnt == BEAT_LAST) || (fifo_num_vld == NV_WIDTH'(1));

  // NOTE: combinational outputs are plain continuous assigns, so there is no
  // partially-assigned always_comb that could infer a latch.
  assign fifo_rd   = (state == BURST) && !fifo_empty && !skid_full && !flush;
  assign push_beat = '{data: fifo_rd_data, sop: (beat_cnt == '0), eop: beat_eop};
  assign busy      = (state != drain_state_e'(DRAIN_IDLE)) || (skid_cnt != 2'd0);

  sfifo_skid2 #(
    .W ($bits(beat_t))
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (fifo_rd),
    .push_data (push_beat),
    .full      (skid_full),
    .cnt       (skid_cnt),
    .pop_rdy   (st.out_rdy),
    .out_vld   (skid_vld),
    .out_data  (head)
  );

  assign st.out_vld  = skid_vld;
  assign st.out_data = head.data;
  assign st.out_sop  = head.sop;
  assign st.out_eop  = head.eop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      timer       <= '0;
      beat_cnt    <= '0;
      timeout_evt <= 1'b0;
    end else if (flush) begin
      state       <= IDLE;
      timer       <= '0;
      beat_cnt    <= '0;
      timeout_evt <= 1'b0;
    end else begin
      timeout_evt <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state <= WAIT;
            timer <= '0;
          end
        end
        WAIT: begin
          if (!fifo_tempty) begin
            state <= BURST;
          end else if (timer == TMR_LAST) begin
            state       <= BURST;
            timeout_evt <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        BURST: begin
          if (fifo_rd) begin
            if (beat_eop) begin
              state    <= IDLE;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + BW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sfifo_burst_drain.sv
// Bench for sfifo_burst_drain: a queue stands in for the sfifo (DEPTH=4,
// ETHRESH=2); a frame-level scoreboard predicts every output beat.
module tb_sfifo_burst_drain;
  import sfifo_drain_pkg::*;

  localparam int WIDTH     = 4;
  localparam int DEPTH     = 4;
  localparam int ETHRESH   = 2;
  localparam int MAX_BURST = 4;
  localparam int TIMEOUT   = 16;
  localparam int NVW       = nv_width(DEPTH);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             fifo_rd;
  logic [WIDTH-1:0] fifo_rd_data;
  logic             fifo_empty;
  logic             fifo_tempty;
  logic [NVW-1:0]   fifo_num_vld;
  logic             timeout_evt;
  logic             busy;

  sfifo_burst_drain_if #(.WIDTH(WIDTH)) st_if ();

  sfifo_burst_drain #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .fifo_rd      (fifo_rd),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .fifo_tempty  (fifo_tempty),
    .fifo_num_vld (fifo_num_vld),
    .st           (st_if),
    .timeout_evt  (timeout_evt),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             sop;
    logic             eop;
  } beat_t;

  typedef struct {
    bit               wr;
    logic [WIDTH-1:0] wd;
    bit               rd;
    bit               vld;
    logic [WIDTH-1:0] data;
    bit               sop;
    bit               eop;
    bit               bsy;
  } vec_t;

  logic [WIDTH-1:0] fq[$];
  beat_t            exp_q[$];
  int               frame_lens[$];
  int vectors = 0, miscompares = 0;
  int cyc = 0, pops = 0, accepted = 0;
  int burst_beats = 0, last_eop_pop = -1, cur_len = 0;
  bit               pend_wr = 1'b0;
  logic [WIDTH-1:0] pend_wd = '0;
  bit               prev_stall = 1'b0;
  beat_t            prev_beat = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fifo_outputs();
    fifo_empty   = (fq.size() == 0);
    fifo_tempty  = (fq.size() < ETHRESH);
    fifo_num_vld = NVW'(fq.size());
    fifo_rd_data = (fq.size() != 0) ? fq[0] : '0;
  endtask

  task automatic drive(input bit wr, input logic [WIDTH-1:0] wd, input bit rdy, input bit fl);
    pend_wr        = wr;
    pend_wd        = wd;
    st_if.out_rdy  = rdy;
    flush          = fl;
    #1;
  endtask

  // Scores this cycle's handshakes, crosses the clock edge, updates the FIFO.
  task automatic advance();
    beat_t cur, e;
    bit    rd_now, acc_now;
    rd_now  = fifo_rd;
    acc_now = st_if.out_vld && st_if.out_rdy;
    cur = '{data: st_if.out_data, sop: st_if.out_sop, eop: st_if.out_eop};
    if (flush) begin
      check("flush_no_pop", fifo_rd, 0);
    end else begin
      if (prev_stall) begin
        check("hold_vld", st_if.out_vld, 1);
        check("hold_beat", cur, prev_beat);
      end
      if (acc_now) begin
        if (exp_q.size() == 0) begin
          check("spurious_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("beat", cur, e);
          accepted++;
          cur_len++;
          if (cur.eop) begin
            frame_lens.push_back(cur_len);
            cur_len = 0;
          end
        end
      end
      if (rd_now) begin
        check("pop_not_empty", fq.size() != 0, 1);
        if (fq.size() != 0) begin
          e.data = fq[0];
          e.sop  = (burst_beats == 0);
          e.eop  = (burst_beats == MAX_BURST - 1) || (fq.size() == 1);
          if (e.sop && last_eop_pop >= 0) check("burst_gap", (cyc - last_eop_pop) >= 3, 1);
          if (e.eop) begin
            burst_beats  = 0;
            last_eop_pop = cyc;
          end else begin
            burst_beats++;
          end
          exp_q.push_back(e);
          pops++;
          check("skid_depth", exp_q.size() <= 2, 1);
        end
      end
    end
    prev_stall = !flush && st_if.out_vld && !st_if.out_rdy;
    prev_beat  = cur;
    @(posedge clk);
    #1;
    if (flush) begin
      fq.delete();
      exp_q.delete();
      burst_beats  = 0;
      last_eop_pop = -1;
      cur_len      = 0;
    end else begin
      if (rd_now && fq.size() != 0) void'(fq.pop_front());
      if (pend_wr && fq.size() < DEPTH) fq.push_back(pend_wd);
    end
    cyc++;
    fifo_outputs();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, '0, 1, 0);
      advance();
    end
  endtask

  function automatic vec_t mk(input bit wr, input int wd, input bit rd, input bit vld,
                              input int data, input bit sop, input bit eop, input bit bsy);
    vec_t v;
    v.wr = wr; v.wd = WIDTH'(wd); v.rd = rd; v.vld = vld;
    v.data = WIDTH'(data); v.sop = sop; v.eop = eop; v.bsy = bsy;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[9];
    int   acc0, d, fl_cnt;
    bit   got;

    // Four back-to-back writes drained at full rate: WAIT for one cycle,
    // then beats 1..4 with sop on the first and eop on the last.
    tbl[0] = mk(1, 1, 0, 0, 0, 0, 0, 0);
    tbl[1] = mk(1, 2, 0, 0, 0, 0, 0, 0);
    tbl[2] = mk(1, 3, 0, 0, 0, 0, 0, 1);
    tbl[3] = mk(1, 4, 1, 0, 0, 0, 0, 1);
    tbl[4] = mk(0, 0, 1, 1, 1, 1, 0, 1);
    tbl[5] = mk(0, 0, 1, 1, 2, 0, 0, 1);
    tbl[6] = mk(0, 0, 1, 1, 3, 0, 0, 1);
    tbl[7] = mk(0, 0, 0, 1, 4, 0, 1, 1);
    tbl[8] = mk(0, 0, 0, 0, 0, 0, 0, 0);

    st_if.out_rdy = 1'b0;
    fifo_outputs();
    #2;
    check("rst_out_vld", st_if.out_vld, 0);
    check("rst_out_data", st_if.out_data, 0);
    check("rst_sop_eop", {st_if.out_sop, st_if.out_eop}, 0);
    check("rst_timeout_evt", timeout_evt, 0);
    check("rst_busy", busy, 0);
    check("rst_fifo_rd", fifo_rd, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].wr, tbl[i].wd, 1, 0);
      check($sformatf("t1_rd[%0d]", i), fifo_rd, tbl[i].rd);
      check($sformatf("t1_vld[%0d]", i), st_if.out_vld, tbl[i].vld);
      check($sformatf("t1_busy[%0d]", i), busy, tbl[i].bsy);
      check($sformatf("t1_tevt[%0d]", i), timeout_evt, 0);
      if (tbl[i].vld)
        check($sformatf("t1_beat[%0d]", i), {st_if.out_data, st_if.out_sop, st_if.out_eop},
              {tbl[i].data, tbl[i].sop, tbl[i].eop});
      advance();
    end

    // Single lonely beat: forced burst TIMEOUT cycles after WAIT entry.
    for (int i = 0; i < 20; i++) begin
      drive(i == 0, 4'hA, 1, 0);
      check($sformatf("t2_tevt[%0d]", i), timeout_evt, i == 18);
      if (i == 18) check("t2_rd", fifo_rd, 1);
      if (i == 19) check("t2_beat", {st_if.out_vld, st_if.out_data, st_if.out_sop, st_if.out_eop},
                         {1'b1, 4'hA, 1'b1, 1'b1});
      advance();
    end
    idle(2);

    // Back-pressure: only two pops while out_rdy is low, head held stable.
    pops = 0;
    acc0 = accepted;
    for (int i = 0; i < 4; i++) begin
      drive(1, WIDTH'(i + 5), 0, 0);
      advance();
    end
    for (int i = 0; i < 10; i++) begin
      drive(0, '0, 0, 0);
      advance();
    end
    check("t3_pops_stalled", pops, 2);
    check("t3_head", {st_if.out_vld, st_if.out_data, st_if.out_sop}, {1'b1, 4'h5, 1'b1});
    for (int i = 0; i < 40 && (busy || fq.size() != 0); i++) begin
      drive(0, '0, 1, 0);
      advance();
    end
    check("t3_accepted", accepted - acc0, 4);
    check("t3_drained", busy, 0);

    // Continuous writes: every complete burst is MAX_BURST beats long.
    frame_lens.delete();
    d = 0;
    for (int i = 0; i < 60; i++) begin
      drive(fq.size() < DEPTH, WIDTH'(d), 1, 0);
      if (fq.size() < DEPTH) d++;
      advance();
    end
    for (int i = 0; i < 40 && (busy || fq.size() != 0); i++) begin
      drive(0, '0, 1, 0);
      advance();
    end
    check("t4_frames", frame_lens.size() >= 5, 1);
    for (int i = 0; i + 1 < frame_lens.size(); i++)
      check($sformatf("t4_len[%0d]", i), frame_lens[i], MAX_BURST);

    // Flush after two accepted beats, then a clean restart with sop.
    acc0 = accepted;
    for (int i = 0; i < 30 && (accepted - acc0) < 2; i++) begin
      drive(i < 4, WIDTH'(i + 9), 1, 0);
      advance();
    end
    check("t5_two_accepted", accepted - acc0, 2);
    drive(0, '0, 1, 1);
    check("t5_rd_in_flush", fifo_rd, 0);
    advance();
    drive(0, '0, 1, 0);
    check("t5_vld_after", st_if.out_vld, 0);
    check("t5_busy_after", busy, 0);
    advance();
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      drive(i < 3, WIDTH'(i + 2), 1, 0);
      if (st_if.out_vld && st_if.out_rdy) begin
        check("t5_restart_sop", st_if.out_sop, 1);
        check("t5_restart_data", st_if.out_data, 2);
        got = 1'b1;
      end
      advance();
    end
    check("t5_restart_seen", got, 1);

    // Random writes, back-pressure and occasional flushes.
    fl_cnt = 0;
    for (int i = 0; i < 10000; i++) begin
      drive((fq.size() < DEPTH) && ($urandom_range(0, 1) == 1), WIDTH'($urandom),
            $urandom_range(0, 9) < 7, $urandom_range(0, 499) == 0);
      if (flush) fl_cnt++;
      advance();
    end
    for (int i = 0; i < 200 && (busy || st_if.out_vld || fq.size() != 0); i++) begin
      drive(0, '0, 1, 0);
      advance();
    end
    check("t6_final_busy", busy, 0);
    check("t6_final_vld", st_if.out_vld, 0);
    check("t6_scoreboard_empty", exp_q.size(), 0);
    check("t6_fifo_drained", fq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
